// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: frame-level controller of the UART receiver.
// It detects the start bit and runs the oversampling edge counter and the bit
// counter. It strobes the sampler, the deserializer and the start, parity and
// stop checkers, then reports data_valid or an error pulse when the frame ends.
module uart_rx_fsm #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               dat_samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               par_error,
  output logic               frm_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_W);

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [3:0]         bit_q, bit_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               par_flag_q, par_flag_d;
  logic               stp_flag_q, stp_flag_d;

  logic [PRESC_W-1:0] presc_sel;
  logic [PRESC_W-1:0] half;
  logic               last_edge;
  logic               strobe;

  // Only 8, 16 and 32 are legal ratios; anything else runs as 8.
  always_comb begin
    if (prescale == PRESC_W'(16) || prescale == PRESC_W'(32)) begin
      presc_sel = prescale;
    end else begin
      presc_sel = PRESC_W'(8);
    end
  end

  // Edge decode against the ratio latched for this frame.
  always_comb begin
    half      = presc_q >> 1;
    last_edge = (edge_q == presc_q - PRESC_W'(1));
    strobe    = (edge_q == half + PRESC_W'(2));
  end

  // State, counters, latched prescale and sticky checker flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      presc_q    <= '0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      presc_q    <= presc_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
    end
  end

  // Next-state, counter update and per-state strobes.
  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    bit_d       = bit_q;
    presc_d     = presc_q;
    par_flag_d  = par_flag_q;
    stp_flag_d  = stp_flag_q;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    par_error   = 1'b0;
    frm_error   = 1'b0;

    // Shared counting for every bit-carrying state; per-state code may override.
    if (state_q == S_START || state_q == S_DATA ||
        state_q == S_PARITY || state_q == S_STOP) begin
      dat_samp_en = 1'b1;
      if (last_edge) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + PRESC_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        edge_d     = '0;
        bit_d      = '0;
        par_flag_d = 1'b0;
        stp_flag_d = 1'b0;
        if (!rx_in) begin
          presc_d = presc_sel;
          state_d = S_START;
        end
      end
      S_START: begin
        strt_chk_en = strobe;
        if (last_edge) begin
          if (strt_glitch) begin
            state_d = S_IDLE;
            edge_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        deser_en = strobe;
        if (last_edge && bit_q == LAST_DATA_BIT) begin
          state_d = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        par_chk_en = strobe;
        if (last_edge) begin
          par_flag_d = par_flag_q | par_err;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        stp_chk_en = strobe;
        if (last_edge) begin
          stp_flag_d = stp_flag_q | stp_err;
          state_d    = S_DONE;
          edge_d     = '0;
          bit_d      = '0;
        end
      end
      S_DONE: begin
        data_valid = !par_flag_q && !stp_flag_q;
        par_error  = par_flag_q;
        frm_error  = stp_flag_q;
        par_flag_d = 1'b0;
        stp_flag_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives whole frames on rx_in, models the
// external deserializer and counts strobes and result pulses per test.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, par_error, frm_error;

  uart_rx_fsm #(.DATA_W(8), .PRESC_W(6)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .par_error(par_error),
    .frm_error(frm_error)
  );

  always #5 clk = ~clk;

  logic [17:0] outv;
  assign outv = {dat_samp_en, edge_cnt, bit_cnt, deser_en, strt_chk_en,
                 par_chk_en, stp_chk_en, data_valid, par_error, frm_error};

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cumulative counters, deserializer model, strobe position check.
  int unsigned exp_m2 = 6;
  int unsigned deser_cnt = 0, dv_cnt = 0, pe_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int unsigned samp_cnt = 0, strt_cnt = 0, parc_cnt = 0, stpc_cnt = 0, bad_cnt = 0;
  logic [7:0] shreg = '0;
  logic [7:0] dv_byte [32];
  int unsigned dv_cyc [32];

  always @(negedge clk) begin
    if (dat_samp_en) samp_cnt++;
    if (strt_chk_en) begin
      strt_cnt++;
      if (32'(edge_cnt) != exp_m2 || bit_cnt != 4'd0) bad_cnt++;
    end
    if (par_chk_en) parc_cnt++;
    if (stp_chk_en) stpc_cnt++;
    if (deser_en) begin
      deser_cnt++;
      if (32'(edge_cnt) != exp_m2 || bit_cnt < 4'd1 || bit_cnt > 4'd8) bad_cnt++;
      shreg = {rx_in, shreg[7:1]};
    end
    if (par_error) pe_cnt++;
    if (frm_error) fe_cnt++;
    if (par_error && frm_error) both_cnt++;
    if (data_valid) begin
      dv_byte[dv_cnt % 32] = shreg;
      dv_cyc[dv_cnt % 32]  = cyc;
      dv_cnt++;
    end
  end

  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  int unsigned b_deser, b_dv, b_pe, b_fe, b_both, b_samp, b_strt, b_parc, b_stpc, b_bad;

  task automatic snap();
    b_deser = deser_cnt; b_dv = dv_cnt; b_pe = pe_cnt; b_fe = fe_cnt;
    b_both = both_cnt; b_samp = samp_cnt; b_strt = strt_cnt; b_parc = parc_cnt;
    b_stpc = stpc_cnt; b_bad = bad_cnt;
  endtask

  task automatic expect_counts(input string t, input int unsigned deser, input int unsigned dv,
                               input int unsigned pe, input int unsigned fe, input int unsigned samp);
    check({t, "_deser"}, deser_cnt - b_deser, deser);
    check({t, "_dv"}, dv_cnt - b_dv, dv);
    check({t, "_parerr"}, pe_cnt - b_pe, pe);
    check({t, "_frmerr"}, fe_cnt - b_fe, fe);
    check({t, "_sampcyc"}, samp_cnt - b_samp, samp);
    check({t, "_strobepos"}, bad_cnt - b_bad, 0);
  endtask

  function automatic logic lbit(input logic [7:0] b, input bit pe, input int unsigned i);
    if (i == 0) return 1'b0;
    if (i <= 8) begin
      logic [7:0] t;
      t = b;
      return t[i-1];
    end
    if (i == 9 && pe) return ^b;
    return 1'b1;
  endfunction

  // Drives one frame; START is entered at the first posedge after rx_in drops.
  // abort_k >= 0 pulls rst low during cycle abort_k of the frame.
  task automatic run_frame(input logic [7:0] b, input int unsigned pin, input bit pe,
                           input bit glitch, input bit perr, input bit serr,
                           input int unsigned nbits, input int abort_k,
                           input int unsigned tail, output int unsigned n0);
    int unsigned peff;
    peff   = (pin == 16 || pin == 32) ? pin : 8;
    exp_m2 = peff / 2 + 2;
    n0     = 0;
    @(posedge clk); #1;
    prescale = 6'(pin); par_en = pe; strt_glitch = glitch;
    par_err = perr; stp_err = serr; rx_in = 1'b0;
    for (int k = 0; k < int'(peff * nbits); k++) begin
      @(posedge clk); #1;
      if (k == 0) n0 = cyc;
      if (k == abort_k) begin
        check("abort_bitcnt", 32'(bit_cnt), 4);
        check("abort_edgecnt", 32'(edge_cnt), 2);
        rst = 1'b0;
        #1;
        check("abort_outs_zero", 32'(outv), 0);
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      if (glitch) rx_in = (k >= 2) ? 1'b1 : 1'b0;
      else rx_in = lbit(b, pe, int'(k) / peff);
    end
    rx_in = 1'b1;
    repeat (tail) @(posedge clk);
  endtask

  int unsigned n0, n1;

  initial begin
    // Reset state, clocked with rx_in low to show reset dominates.
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_zero", 32'(outv), 0);
    rx_in = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs_zero", 32'(outv), 0);

    // 1: P=8, no parity, 0xA5.
    snap();
    run_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 10, -1, 4, n0);
    expect_counts("t1", 8, 1, 0, 0, 80);
    check("t1_byte", 32'(dv_byte[b_dv % 32]), 32'hA5);
    check("t1_dv_latency", dv_cyc[b_dv % 32] - n0, 80);
    check("t1_strtchk", strt_cnt - b_strt, 1);
    check("t1_parchk", parc_cnt - b_parc, 0);
    check("t1_stpchk", stpc_cnt - b_stpc, 1);
    @(negedge clk);
    check("t1_idle_counters", 32'({edge_cnt, bit_cnt}), 0);

    // 2: P=16 with parity error, then a clean parity frame.
    snap();
    run_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 11, -1, 4, n0);
    expect_counts("t2a", 8, 0, 1, 0, 176);
    check("t2a_parchk", parc_cnt - b_parc, 1);
    snap();
    run_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b0, 11, -1, 4, n0);
    expect_counts("t2b", 8, 1, 0, 0, 176);
    check("t2b_byte", 32'(dv_byte[b_dv % 32]), 32'h5A);

    // 3: start glitch returns to IDLE after one bit time.
    snap();
    run_frame(8'h00, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1, -1, 4, n0);
    expect_counts("t3", 0, 0, 0, 0, 8);
    check("t3_strtchk", strt_cnt - b_strt, 1);
    check("t3_stpchk", stpc_cnt - b_stpc, 0);

    // 4: stop error alone, then parity and stop errors together.
    snap();
    run_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 10, -1, 4, n0);
    expect_counts("t4a", 8, 0, 0, 1, 80);
    snap();
    run_frame(8'h81, 8, 1'b1, 1'b0, 1'b1, 1'b1, 11, -1, 4, n0);
    expect_counts("t4b", 8, 0, 1, 1, 88);
    check("t4b_both", both_cnt - b_both, 1);

    // 5: reset mid-DATA, then a clean frame.
    snap();
    run_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 10, 34, 0, n0);
    @(negedge clk);
    check("t5_abort_dv", dv_cnt - b_dv, 0);
    check("t5_abort_err", (pe_cnt - b_pe) + (fe_cnt - b_fe), 0);
    snap();
    run_frame(8'h6E, 8, 1'b0, 1'b0, 1'b0, 1'b0, 10, -1, 4, n0);
    expect_counts("t5", 8, 1, 0, 0, 80);
    check("t5_byte", 32'(dv_byte[b_dv % 32]), 32'h6E);

    // 6: P=32 back-to-back frames with parity, then an illegal ratio.
    snap();
    run_frame(8'h00, 32, 1'b1, 1'b0, 1'b0, 1'b0, 11, -1, 0, n0);
    run_frame(8'hFF, 32, 1'b1, 1'b0, 1'b0, 1'b0, 11, -1, 4, n1);
    expect_counts("t6a", 16, 2, 0, 0, 704);
    check("t6a_byte0", 32'(dv_byte[b_dv % 32]), 32'h00);
    check("t6a_byte1", 32'(dv_byte[(b_dv + 1) % 32]), 32'hFF);
    snap();
    run_frame(8'h96, 20, 1'b0, 1'b0, 1'b0, 1'b0, 10, -1, 4, n0);
    expect_counts("t6b", 8, 1, 0, 0, 80);
    check("t6b_byte", 32'(dv_byte[b_dv % 32]), 32'h96);
    check("t6b_dv_latency", dv_cyc[b_dv % 32] - n0, 80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
